// File: rtl/vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_fetcher
// Description : Line-prefetch controller between the SDRAM read port and the
//               VGA timing generator. Fetches each visible line of a 640x480
//               12-bit framebuffer into a ping-pong pair of line buffers one
//               line ahead of the scan, and serves the current line's pixels.
// Ports       : i_clk_25 / i_rst                    - pixel clock, async reset
//               i_current_x/y, i_active_d, i_vs     - scan position and syncs
//               o_red/o_green/o_blue                - registered pixel colour
//               o_rd_req/o_rd_addr/i_rd_ack         - burst read request
//               i_rd_valid/i_rd_data                - read data beats
//               o_busy, o_underrun                  - fetch status
// Revision    : 1.0 - initial release
// ============================================================================
module vga_line_fetcher #(
    parameter int FB_BASE   = 0,
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 24
) (
    input  logic              i_clk_25,
    input  logic              i_rst,
    input  logic [9:0]        i_current_x,
    input  logic [9:0]        i_current_y,
    input  logic              i_active_d,
    input  logic              i_vs,
    output logic [3:0]        o_red,
    output logic [3:0]        o_green,
    output logic [3:0]        o_blue,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [15:0]       i_rd_data,
    output logic              o_busy,
    output logic              o_underrun
);

    localparam int c_NUM_BURSTS = 640 / BURST_LEN;
    localparam int c_BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_BIDX_W     = (c_NUM_BURSTS > 1) ? $clog2(c_NUM_BURSTS) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT  = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_BIDX_W-1:0] c_LAST_BURST = c_BIDX_W'(c_NUM_BURSTS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                r_vs_q;
    logic                r_active_q;
    logic                r_trig;
    logic [8:0]          r_trig_line;
    logic [8:0]          r_line;
    logic [c_BIDX_W-1:0] r_burst;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_underrun;
    logic [11:0]         r_pix;
    logic [11:0]         r_buf0 [0:639];
    logic [11:0]         r_buf1 [0:639];

    logic                w_vs_fall;
    logic                w_act_fetch;
    logic [9:0]          w_y_next;
    logic                w_last_beat;
    logic                w_last_burst;
    logic                w_beat_wr;
    logic [9:0]          w_wr_idx;
    logic [9:0]          w_rd_x;
    logic [ADDR_W-1:0]   w_line_ext;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_unused;

    // Only the 12 colour bits of each word are stored.
    assign w_unused = &{1'b0, i_rd_data[15:12], w_y_next[9]};

    // ---------------------------------------------------------------- triggers
    assign w_vs_fall   = r_vs_q & ~i_vs;
    assign w_y_next    = i_current_y + 10'd1;
    assign w_act_fetch = ~r_active_q & i_active_d & (i_current_y < 10'd479);

    // The detected edge is registered so the FSM acts on it one cycle later;
    // frame start wins if both fire together.
    always_ff @(posedge i_clk_25 or posedge i_rst) begin
        if (i_rst) begin
            r_vs_q      <= 1'b0;
            r_active_q  <= 1'b0;
            r_trig      <= 1'b0;
            r_trig_line <= 9'd0;
        end else begin
            r_vs_q      <= i_vs;
            r_active_q  <= i_active_d;
            r_trig      <= w_vs_fall | w_act_fetch;
            r_trig_line <= w_vs_fall ? 9'd0 : w_y_next[8:0];
        end
    end

    // ---------------------------------------------------------------- FSM
    assign w_last_beat  = (r_beat == c_LAST_BEAT);
    assign w_last_burst = (r_burst == c_LAST_BURST);
    assign w_beat_wr    = (r_state == c_DATA) & i_rd_valid;

    always_ff @(posedge i_clk_25 or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (r_trig)   w_state_next = c_REQ;
            c_REQ:   if (i_rd_ack) w_state_next = c_DATA;
            c_DATA:  if (w_beat_wr && w_last_beat)
                         w_state_next = w_last_burst ? c_IDLE : c_REQ;
            default: w_state_next = c_IDLE;
        endcase
    end

    // line*640 as (line<<9)+(line<<7); burst offset is a shift because
    // BURST_LEN is a power of two.
    assign w_line_ext = ADDR_W'(r_line);
    assign w_addr     = ADDR_W'(FB_BASE) + (w_line_ext << 9) + (w_line_ext << 7)
                      + (ADDR_W'(r_burst) << c_BEAT_W);

    always_comb begin
        o_rd_req  = 1'b0;
        o_busy    = 1'b0;
        o_rd_addr = '0;
        case (r_state)
            c_REQ: begin
                o_rd_req  = 1'b1;
                o_busy    = 1'b1;
                o_rd_addr = w_addr;
            end
            c_DATA: o_busy = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- counters
    // Any trigger that is seen outside IDLE (including on the final beat of a
    // line) is dropped and flagged.
    always_ff @(posedge i_clk_25 or posedge i_rst) begin
        if (i_rst) begin
            r_line     <= 9'd0;
            r_burst    <= '0;
            r_beat     <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (r_trig && (r_state == c_IDLE)) begin
                r_line  <= r_trig_line;
                r_burst <= '0;
                r_beat  <= '0;
            end
            if (r_trig && (r_state != c_IDLE)) begin
                r_underrun <= 1'b1;
            end
            if (w_beat_wr) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    if (!w_last_burst) begin
                        r_burst <= r_burst + c_BIDX_W'(1);
                    end
                end else begin
                    r_beat <= r_beat + c_BEAT_W'(1);
                end
            end
        end
    end

    assign o_underrun = r_underrun;

    // ---------------------------------------------------------------- buffers
    assign w_wr_idx = (10'(r_burst) << c_BEAT_W) + 10'(r_beat);

    always_ff @(posedge i_clk_25) begin
        if (w_beat_wr) begin
            if (r_line[0]) begin
                r_buf1[w_wr_idx] <= i_rd_data[11:0];
            end else begin
                r_buf0[w_wr_idx] <= i_rd_data[11:0];
            end
        end
    end

    // Out-of-range x (blanking) reads a harmless in-range location.
    assign w_rd_x = (i_current_x < 10'd640) ? i_current_x : 10'd0;

    always_ff @(posedge i_clk_25) begin
        r_pix <= i_current_y[0] ? r_buf1[w_rd_x] : r_buf0[w_rd_x];
    end

    // r_active_q is the one-cycle-delayed active flag; it also blanks the
    // colour during reset.
    assign o_red   = r_active_q ? r_pix[11:8] : 4'h0;
    assign o_green = r_active_q ? r_pix[7:4]  : 4'h0;
    assign o_blue  = r_active_q ? r_pix[3:0]  : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_line_fetcher
// Description : Self-checking bench for vga_line_fetcher. Request addresses
//               and pixel colours are pushed to scoreboard queues when the
//               stimulus is driven and popped when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_line_fetcher;

    localparam int FB_BASE   = 0;
    localparam int BURST_LEN = 8;
    localparam int ADDR_W    = 24;
    localparam int NB        = 640 / BURST_LEN;

    logic              clk_25 = 1'b0;
    logic              rst = 1'b0;
    logic [9:0]        current_x = '0;
    logic [9:0]        current_y = '0;
    logic              active_d = 1'b0;
    logic              vs = 1'b1;
    logic [3:0]        red, green, blue;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack = 1'b0;
    logic              rd_valid = 1'b0;
    logic [15:0]       rd_data = '0;
    logic              busy, underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] q_addr [$];
    logic [11:0]       q_pix  [$];

    always #20 clk_25 = ~clk_25;

    vga_line_fetcher #(
        .FB_BASE  (FB_BASE),
        .BURST_LEN(BURST_LEN),
        .ADDR_W   (ADDR_W)
    ) dut (
        .i_clk_25   (clk_25),
        .i_rst      (rst),
        .i_current_x(current_x),
        .i_current_y(current_y),
        .i_active_d (active_d),
        .i_vs       (vs),
        .o_red      (red),
        .o_green    (green),
        .o_blue     (blue),
        .o_rd_req   (rd_req),
        .o_rd_addr  (rd_addr),
        .i_rd_ack   (rd_ack),
        .i_rd_valid (rd_valid),
        .i_rd_data  (rd_data),
        .o_busy     (busy),
        .o_underrun (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int line, input int idx);
        if (line == 2) return 12'hA53;
        if (line == 3) return 12'h5C1;
        return 12'(line * 37 + idx * 5);
    endfunction

    task automatic push_line(input int line);
        for (int b = 0; b < NB; b++)
            q_addr.push_back(ADDR_W'(FB_BASE + line * 640 + b * BURST_LEN));
    endtask

    // Acts as the SDRAM: accepts every burst of one line and returns data.
    task automatic serve_line(input int line, input int ack_delay, input bit junk,
                              output int cycles);
        int n;
        logic [ADDR_W-1:0] exp;
        cycles = 0;
        for (int b = 0; b < NB; b++) begin
            n = 0;
            while (!rd_req && n < 60) begin
                @(negedge clk_25);
                n++;
                cycles++;
            end
            if (!rd_req) begin
                check("req_timeout", 32'd0, 32'd1);
                return;
            end
            exp = (q_addr.size() > 0) ? q_addr.pop_front() : '1;
            check("rd_addr", rd_addr, exp);
            if (b == 0) begin
                for (int d = 0; d < ack_delay; d++) begin
                    rd_valid = junk;
                    rd_data  = 16'hFFFF;
                    @(negedge clk_25);
                    cycles++;
                    check("req_hold", rd_req, 1'b1);
                    check("addr_hold", rd_addr, exp);
                end
                rd_valid = 1'b0;
            end
            rd_ack = 1'b1;
            @(negedge clk_25);
            cycles++;
            rd_ack = 1'b0;
            if (b == 0) check("req_drop", rd_req, 1'b0);
            for (int k = 0; k < BURST_LEN; k++) begin
                rd_valid = 1'b1;
                rd_data  = {4'hF, pix(line, b * BURST_LEN + k)};
                @(negedge clk_25);
                cycles++;
            end
            rd_valid = 1'b0;
        end
    endtask

    task automatic raise_active(input int y);
        @(negedge clk_25);
        active_d  = 1'b0;
        current_y = 10'(y);
        @(negedge clk_25);
        active_d = 1'b1;
        if (y < 479) push_line(y + 1);
    endtask

    task automatic show_line(input int y, input int line);
        int xs [6] = '{0, 1, 7, 8, 321, 639};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_25);
            if (i > 0) check("pix", {red, green, blue}, q_pix.pop_front());
            current_y = 10'(y);
            current_x = 10'(xs[i]);
            q_pix.push_back(pix(line, xs[i]));
        end
        @(negedge clk_25);
        check("pix", {red, green, blue}, q_pix.pop_front());
    endtask

    task automatic no_req_for(input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(negedge clk_25);
            if (rd_req) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        #5 rst = 1'b1;
        repeat (3) @(negedge clk_25);
        check("rst_req", rd_req, 1'b0);
        check("rst_addr", rd_addr, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_colour", {red, green, blue}, 12'h000);
        rst = 1'b0;
        no_req_for(10, "idle_no_req");

        // Frame start with a slow acknowledge on the first burst.
        @(negedge clk_25);
        vs = 1'b0;
        push_line(0);
        @(negedge clk_25);
        check("req_edge1", rd_req, 1'b0);
        @(negedge clk_25);
        check("req_edge2", rd_req, 1'b1);
        check("addr_frame", rd_addr, ADDR_W'(FB_BASE));
        serve_line(0, 5, 1'b0, cyc);
        vs = 1'b1;
        check("busy_done", busy, 1'b0);

        raise_active(0);
        serve_line(1, 0, 1'b0, cyc);
        check("budget", cyc <= 800, 1'b1);
        show_line(0, 0);
        show_line(1, 1);

        // Line 2 with junk beats during REQ, then junk beats in IDLE.
        raise_active(1);
        serve_line(2, 3, 1'b1, cyc);
        @(negedge clk_25);
        active_d = 1'b0;
        repeat (4) begin
            rd_valid = 1'b1;
            rd_data  = 16'hFFFF;
            @(negedge clk_25);
        end
        rd_valid = 1'b0;
        raise_active(2);
        serve_line(3, 0, 1'b0, cyc);
        show_line(2, 2);
        show_line(3, 3);
        @(negedge clk_25);
        active_d = 1'b0;
        q_pix.push_back(12'h000);
        @(negedge clk_25);
        check("blank", {red, green, blue}, q_pix.pop_front());

        // Last line, then no fetch after line 479.
        raise_active(478);
        serve_line(479, 0, 1'b0, cyc);
        raise_active(479);
        no_req_for(20, "no_fetch_479");
        show_line(479, 479);

        // Underrun: retrigger while the line-101 fetch is running.
        check("underrun_pre", underrun, 1'b0);
        raise_active(100);
        fork
            serve_line(101, 0, 1'b0, cyc);
            begin
                repeat (150) @(negedge clk_25);
                active_d = 1'b0;
                @(negedge clk_25);
                active_d = 1'b1;
                repeat (5) @(negedge clk_25);
                check("underrun_set", underrun, 1'b1);
            end
        join
        check("underrun_sticky", underrun, 1'b1);
        no_req_for(30, "no_extra_req");
        show_line(101, 101);

        // Reset in the middle of a data burst.
        raise_active(200);
        n = 0;
        while (!rd_req && n < 10) begin
            @(negedge clk_25);
            n++;
        end
        check("mid_req_seen", rd_req, 1'b1);
        check("mid_addr", rd_addr, q_addr.pop_front());
        rd_ack = 1'b1;
        @(negedge clk_25);
        rd_ack = 1'b0;
        repeat (3) begin
            rd_valid = 1'b1;
            rd_data  = 16'h0123;
            @(negedge clk_25);
        end
        check("mid_busy", busy, 1'b1);
        #5 rst = 1'b1;
        #1;
        check("arst_req", rd_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_colour", {red, green, blue}, 12'h000);
        check("arst_underrun", underrun, 1'b0);
        rd_valid = 1'b0;
        @(negedge clk_25);
        active_d = 1'b0;
        @(negedge clk_25);
        rst = 1'b0;
        q_addr.delete();
        no_req_for(20, "post_rst_no_req");
        check("post_rst_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
